latch_bank_ctrl: RTL

- Write controller for a bank of NLATCH level-sensitive D latches, each DW bits wide, that share a single data bus.
- Arbitrates write requests from NREQ requesters using round-robin priority.
- Sequences each write as setup → enable → hold so that a latch's D input is stable before its enable rises and stays stable after it falls.
- Sits between requesters and the latch bank: drives the shared latch D bus and one enable per latch.

---
 rtl/latch_bank_ctrl_pkg.sv | 20 ++
 rtl/latch_bank_ctrl_rr_arbiter.sv | 30 +++
 rtl/latch_bank_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/latch_bank_ctrl_pkg.sv
// rtl/latch_bank_ctrl_pkg.sv - shared types and constants for the latch bank write controller
package latch_bank_ctrl_pkg;

  // Width of the enable-phase cycle counter (EN_CYCLES up to 15)
  localparam int CNT_W = 4;

  // Controller state, held in a 2-bit register
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Index width for a set of n items, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/latch_bank_ctrl_rr_arbiter.sv
// rtl/latch_bank_ctrl_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter
  import latch_bank_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_masked,
  input  logic [IW-1:0]   rr_ptr,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] w_j;

  // Scan from rr_ptr upward, wrapping, and take the first eligible requester
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_j       = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_j = IW'((int'(rr_ptr) + i) % NREQ);
      if (!gnt_valid && req_masked[w_j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/latch_bank_ctrl.sv
// rtl/latch_bank_ctrl.sv - round-robin write sequencer for a bank of shared-bus D latches
module latch_bank_ctrl
  import latch_bank_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NLATCH    = 8,
  parameter int DW        = 8,
  parameter int EN_CYCLES = 1,
  localparam int AW = idx_width(NLATCH),
  localparam int IW = idx_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [DW-1:0]        latch_d,
  output logic [NLATCH-1:0]    latch_en,
  output logic                 busy
);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     r_gnt_idx;
  logic [NREQ-1:0]   r_mask;
  logic [AW-1:0]     r_addr;

  logic [NREQ-1:0]   w_req_masked;
  logic              w_gnt_valid;
  logic [IW-1:0]     w_gnt_idx;
  logic              w_grant;
  logic              w_addr_ok;
  logic [NLATCH-1:0] w_en_onehot;
  logic [NREQ-1:0]   w_gnt_onehot;

  // The requester just served is blocked for one IDLE cycle so a late req drop is not re-granted
  assign w_req_masked = req & ~r_mask;
  assign w_grant      = (r_state == ST_IDLE) && w_gnt_valid;
  assign w_addr_ok    = {1'b0, r_addr} < (AW+1)'(NLATCH);
  assign w_en_onehot  = w_addr_ok ? (NLATCH'(1) << r_addr) : '0;
  assign w_gnt_onehot = NREQ'(1) << r_gnt_idx;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_masked (w_req_masked),
    .rr_ptr     (r_rr_ptr),
    .gnt_valid  (w_gnt_valid),
    .gnt_idx    (w_gnt_idx)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state: setup one cycle, enable EN_CYCLES cycles, hold one cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_gnt_valid) w_state_next = ST_SETUP;
      ST_SETUP:  w_state_next = ST_ENABLE;
      ST_ENABLE: if (r_cnt == CNT_W'(EN_CYCLES - 1)) w_state_next = ST_HOLD;
      ST_HOLD:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Counts cycles spent in ENABLE; cleared everywhere else so each enable phase starts at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_cnt <= '0;
    else if (r_state != ST_ENABLE) r_cnt <= '0;
    else                           r_cnt <= r_cnt + CNT_W'(1);
  end

  // Grant capture and round-robin pointer advance; address and data are frozen for the transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      r_addr    <= '0;
    end else if (w_grant) begin
      r_gnt_idx <= w_gnt_idx;
      r_addr    <= req_addr[w_gnt_idx*AW +: AW];
      r_rr_ptr  <= (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + IW'(1);
    end
  end

  // Mask is live only in the IDLE cycle right after HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mask <= '0;
    else     r_mask <= (r_state == ST_HOLD) ? w_gnt_onehot : '0;
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_d  <= '0;
      latch_en <= '0;
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (w_grant) latch_d <= req_data[w_gnt_idx*DW +: DW];
      latch_en <= (w_state_next == ST_ENABLE) ? w_en_onehot : '0;
      ack      <= (w_state_next == ST_HOLD) ? w_gnt_onehot : '0;
      err      <= (w_state_next == ST_HOLD) && !w_addr_ok;
      busy     <= (w_state_next != ST_IDLE);
    end
  end

endmodule
